// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one MUL/DIV/REM/DIVU/REMU request at a time onto the
// multiplier/divider units. Define MULDIV_RESULT_CACHE_EN for a one-entry result cache.
module muldiv_ctrl #(
  parameter int TIMEOUT = 128
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_word,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        unit_start,
  output logic [1:0]  unit_sel,
  output logic [63:0] unit_a,
  output logic [63:0] unit_b,
  output logic        unit_abort,
  input  logic        unit_done,
  input  logic [63:0] unit_prod,
  input  logic [63:0] unit_quot,
  input  logic [63:0] unit_rem
);

  // Handshake: a request transfers on a cycle with req_valid && req_ready, a
  // legal op and no flush. resp_valid is a one-cycle pulse with no back-pressure.

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_DIV  = 3'd1;
  localparam logic [2:0] OP_REM  = 3'd2;
  localparam logic [2:0] OP_DIVU = 3'd3;
  localparam logic [2:0] OP_REMU = 3'd4;
  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;

  state_t          state;
  state_t          state_nx;
  logic [2:0]      op_q;
  logic            word_q;
  logic            err_q;
  logic            abort_q;
  logic [WD_W-1:0] wd;

  logic            accept;
  logic            req_unsigned;
  logic            req_is_div;
  logic            req_is_rem;
  logic [63:0]     prep_a;
  logic [63:0]     prep_b;
  logic [63:0]     most_neg;
  logic            div_zero;
  logic            overflow;
  logic            fast;
  logic [63:0]     fast_raw;
  logic [63:0]     fast_res;
  logic [1:0]      sel_nx;
  logic            cache_hit;
  logic [63:0]     cache_res;
  logic [63:0]     unit_raw;
  logic [63:0]     unit_result;
  logic            unit_take;
  logic            wd_fire;

  function automatic logic [63:0] word_fix(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  assign accept       = (state == IDLE) && req_valid && (req_op <= OP_REMU) && !flush;
  assign req_unsigned = (req_op == OP_DIVU) || (req_op == OP_REMU);
  assign req_is_div   = (req_op != OP_MUL);
  assign req_is_rem   = (req_op == OP_REM) || (req_op == OP_REMU);

  always_comb begin
    prep_a = req_a;
    prep_b = req_b;
    if (req_word) begin
      if (req_unsigned) begin
        prep_a = {32'h0, req_a[31:0]};
        prep_b = {32'h0, req_b[31:0]};
      end else begin
        prep_a = {{32{req_a[31]}}, req_a[31:0]};
        prep_b = {{32{req_b[31]}}, req_b[31:0]};
      end
    end
  end

  // Most-negative value as it appears after word sign-extension.
  assign most_neg = req_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
  assign div_zero = req_is_div && (prep_b == 64'h0);
  assign overflow = ((req_op == OP_DIV) || (req_op == OP_REM)) &&
                    (prep_a == most_neg) && (prep_b == {64{1'b1}});

  always_comb begin
    fast_raw = 64'h0;
    if (div_zero) fast_raw = req_is_rem ? prep_a : {64{1'b1}};
    else if (overflow) fast_raw = req_is_rem ? 64'h0 : prep_a;
  end

  assign fast     = div_zero || overflow || cache_hit;
  assign fast_res = (div_zero || overflow) ? word_fix(req_word, fast_raw) : cache_res;

  always_comb begin
    sel_nx = 2'd0;
    if (req_unsigned) sel_nx = 2'd2;
    else if (req_is_div) sel_nx = 2'd1;
  end

  always_comb begin
    unit_raw = unit_rem;
    if (op_q == OP_MUL) unit_raw = unit_prod;
    else if ((op_q == OP_DIV) || (op_q == OP_DIVU)) unit_raw = unit_quot;
  end

  assign unit_result = word_fix(word_q, unit_raw);
  assign unit_take   = (state == WAIT) && !flush && unit_done;
  // A completion arriving in the same cycle as the timeout still wins.
  assign wd_fire     = (state == WAIT) && !flush && !unit_done && (wd == WD_W'(TIMEOUT));

`ifdef MULDIV_RESULT_CACHE_EN
  logic        c_valid;
  logic [2:0]  c_op;
  logic        c_word;
  logic [63:0] c_a;
  logic [63:0] c_b;
  logic [63:0] c_res;

  assign cache_hit = c_valid && (c_op == req_op) && (c_word == req_word) &&
                     (c_a == prep_a) && (c_b == prep_b);
  assign cache_res = c_res;

  // Only reset invalidates the entry; a flush leaves it intact.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_valid <= 1'b0;
      c_op    <= 3'd0;
      c_word  <= 1'b0;
      c_a     <= 64'h0;
      c_b     <= 64'h0;
      c_res   <= 64'h0;
    end else if (unit_take) begin
      c_valid <= 1'b1;
      c_op    <= op_q;
      c_word  <= word_q;
      c_a     <= unit_a;
      c_b     <= unit_b;
      c_res   <= unit_result;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign cache_res = 64'h0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = fast ? DONE : LAUNCH;
      LAUNCH:  state_nx = WAIT;
      WAIT:    if (unit_done || wd_fire) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE) && !flush;
  assign resp_err   = resp_valid && err_q;
  assign unit_start = (state == LAUNCH);
  assign unit_abort = abort_q || wd_fire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      word_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      wd        <= '0;
      unit_sel  <= 2'd0;
      unit_a    <= 64'h0;
      unit_b    <= 64'h0;
      resp_data <= 64'h0;
    end else begin
      state   <= state_nx;
      abort_q <= flush && ((state == LAUNCH) || (state == WAIT));
      if (accept) begin
        op_q     <= req_op;
        word_q   <= req_word;
        err_q    <= 1'b0;
        unit_sel <= sel_nx;
        unit_a   <= prep_a;
        unit_b   <= prep_b;
        if (fast) resp_data <= fast_res;
      end
      if (state == LAUNCH) wd <= '0;
      else if (state == WAIT) wd <= wd + WD_W'(1);
      if (unit_take) begin
        resp_data <= unit_result;
      end else if (wd_fire) begin
        resp_data <= 64'h0;
        err_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed and random requests against a response
// scoreboard, with a small bench-side unit model supplying completions.
module tb_muldiv_ctrl;

  localparam int TIMEOUT = 128;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic        req_word = 1'b0;
  logic [63:0] req_a = 64'h0;
  logic [63:0] req_b = 64'h0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        unit_start;
  logic [1:0]  unit_sel;
  logic [63:0] unit_a;
  logic [63:0] unit_b;
  logic        unit_abort;
  logic        unit_done = 1'b0;
  logic [63:0] unit_prod = 64'h0;
  logic [63:0] unit_quot = 64'h0;
  logic [63:0] unit_rem = 64'h0;

  muldiv_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_word(req_word), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .unit_start(unit_start), .unit_sel(unit_sel), .unit_a(unit_a), .unit_b(unit_b),
    .unit_abort(unit_abort), .unit_done(unit_done),
    .unit_prod(unit_prod), .unit_quot(unit_quot), .unit_rem(unit_rem)
  );

  always #5 clk = ~clk;

  logic [64:0] exp_q[$];  // {resp_err, resp_data}
  int vectors = 0;
  int miscompares = 0;
  int start_cnt = 0;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (unit_start) start_cnt++;
    if (resp_valid) begin
      if (exp_q.size() == 0) check("spurious_resp", {64'h0, resp_valid}, 65'd0);
      else check("resp", {resp_err, resp_data}, exp_q.pop_front());
    end
  end

  function automatic logic [63:0] prep(input logic [2:0] op, input logic w, input logic [63:0] x);
    if (!w) return x;
    if (op == 3'd3 || op == 3'd4) return {32'h0, x[31:0]};
    return {{32{x[31]}}, x[31:0]};
  endfunction

  function automatic logic [63:0] sx(input logic w, input logic [63:0] v);
    return w ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic [1:0] sel_of(input logic [2:0] op);
    if (op == 3'd0) return 2'd0;
    if (op == 3'd1 || op == 3'd2) return 2'd1;
    return 2'd2;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; returns just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 4 && !req_ready; i++) step();
    req_valid = 1'b1;
    req_op = op;
    req_word = w;
    req_a = a;
    req_b = b;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_start(output logic ok);
    for (int i = 0; i < 4 && !unit_start; i++) step();
    ok = unit_start;
    check("start_seen", {64'h0, unit_start}, 65'd1);
  endtask

  task automatic fast_op(input logic [2:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] exp);
    int s0;
    exp_q.push_back({1'b0, exp});
    s0 = start_cnt;
    send(op, w, a, b);
    check("fast_latency", {64'h0, resp_valid}, 65'd1);
    step();
    check("fast_no_start", start_cnt, s0);
  endtask

  task automatic unit_op(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b,
                         input int dly, input logic [63:0] prod, input logic [63:0] quot,
                         input logic [63:0] rem, input logic [63:0] exp);
    logic ok;
    exp_q.push_back({1'b0, exp});
    send(op, w, a, b);
    wait_start(ok);
    if (!ok) begin
      void'(exp_q.pop_back());
      repeat (4) step();
      return;
    end
    check("unit_sel", unit_sel, sel_of(op));
    check("unit_ops", {1'b0, unit_a ^ unit_b}, {1'b0, prep(op, w, a) ^ prep(op, w, b)});
    repeat (dly) step();
    unit_done = 1'b1;
    unit_prod = prod;
    unit_quot = quot;
    unit_rem = rem;
    step();
    unit_done = 1'b0;
    check("unit_resp_latency", {64'h0, resp_valid}, 65'd1);
    step();
  endtask

  initial begin
    logic ok;
    int abort_at;
    int s0;
    logic [2:0] op;
    logic w;
    logic [63:0] a, b, p, q, r, e;

    repeat (2) step();
    reset = 1'b0;
    check("reset_ready", {64'h0, req_ready}, 65'd1);
    check("reset_outs", {60'h0, resp_valid, resp_err, unit_start, unit_abort, unit_sel}, 65'd0);
    check("reset_data", {1'b0, resp_data | unit_a | unit_b}, 65'd0);

    // Signed divide through the unit, completion 10 cycles after launch.
    unit_op(3'd1, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 10, 64'h0,
            64'hFFFF_FFFF_FFFF_FFF2, 64'h2, 64'hFFFF_FFFF_FFFF_FFF2);
    check("resp_held", {1'b0, resp_data}, {1'b0, 64'hFFFF_FFFF_FFFF_FFF2});

    fast_op(3'd3, 1'b0, 64'd5, 64'd0, {64{1'b1}});
    fast_op(3'd4, 1'b0, 64'd5, 64'd0, 64'd5);
    fast_op(3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
    fast_op(3'd2, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h0);
    fast_op(3'd1, 1'b0, 64'h8000_0000_0000_0000, {64{1'b1}}, 64'h8000_0000_0000_0000);
    fast_op(3'd4, 1'b1, 64'h1234_5678_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000);

    unit_op(3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 1, 64'h0000_0000_FFFF_FFFE, 64'h0, 64'h0,
            64'hFFFF_FFFF_FFFF_FFFE);
    unit_op(3'd4, 1'b1, 64'hF000_0000_9000_0007, 64'h5, 3, 64'h0, 64'h0,
            64'h0000_0000_8000_0001, 64'hFFFF_FFFF_8000_0001);

    for (int i = 0; i < 8; i++) begin
      op = 3'($urandom_range(0, 4));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      b[1:0] = 2'b01;
      p = {$urandom, $urandom};
      q = {$urandom, $urandom};
      r = {$urandom, $urandom};
      e = (op == 3'd0) ? p : ((op == 3'd1 || op == 3'd3) ? q : r);
      unit_op(op, w, a, b, $urandom_range(1, 6), p, q, r, sx(w, e));
    end
    for (int i = 0; i < 6; i++) begin
      op = 3'($urandom_range(1, 4));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      b = w ? {$urandom, 32'h0} : 64'h0;
      e = (op == 3'd2 || op == 3'd4) ? prep(op, w, a) : {64{1'b1}};
      fast_op(op, w, a, b, sx(w, e));
    end

    // Reserved op, flush with a request, and a stray unit_done in IDLE are all ignored.
    s0 = start_cnt;
    send(3'd6, 1'b0, 64'd1, 64'd1);
    check("reserved_idle", {64'h0, req_ready}, 65'd1);
    req_valid = 1'b1; req_op = 3'd0; flush = 1'b1;
    step();
    req_valid = 1'b0; flush = 1'b0;
    check("flush_idle_ready", {64'h0, req_ready}, 65'd1);
    unit_done = 1'b1;
    step();
    unit_done = 1'b0;
    step();
    check("ignored_no_start", start_cnt, s0);

    // Flush colliding with unit_done in WAIT.
    send(3'd1, 1'b0, 64'd77, 64'd7);
    wait_start(ok);
    step();
    unit_done = 1'b1; unit_quot = 64'd11; flush = 1'b1;
    step();
    unit_done = 1'b0; flush = 1'b0;
    check("flush_wait_abort", {63'h0, unit_abort, req_ready}, 65'd3);
    step();
    check("abort_one_cycle", {64'h0, unit_abort}, 65'd0);

    // Flush during LAUNCH.
    send(3'd3, 1'b0, 64'd9, 64'd3);
    wait_start(ok);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_launch_abort", {63'h0, unit_abort, req_ready}, 65'd3);
    step();

    // Reset in the middle of WAIT.
    send(3'd2, 1'b0, 64'd1000, 64'd33);
    wait_start(ok);
    repeat (2) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_ctl", {60'h0, req_ready, resp_valid, unit_abort, unit_sel}, 65'h10);
    check("midreset_data", {1'b0, resp_data | unit_a | unit_b}, 65'd0);

    // Watchdog: unit never completes.
    exp_q.push_back({1'b1, 64'h0});
    send(3'd0, 1'b0, 64'd123, 64'd456);
    wait_start(ok);
    abort_at = 0;
    for (int n = 1; n <= TIMEOUT + 2 && !resp_valid; n++) begin
      step();
      if (unit_abort && abort_at == 0) abort_at = n;
    end
    check("wd_abort_cycle", abort_at, TIMEOUT + 1);
    check("wd_resp", {63'h0, resp_valid, resp_err}, 65'd3);
    step();

    // Repeated MUL 3*4.
    unit_op(3'd0, 1'b0, 64'd3, 64'd4, 2, 64'd12, 64'h0, 64'h0, 64'd12);
`ifdef MULDIV_RESULT_CACHE_EN
    fast_op(3'd0, 1'b0, 64'd3, 64'd4, 64'd12);
`else
    s0 = start_cnt;
    unit_op(3'd0, 1'b0, 64'd3, 64'd4, 2, 64'd12, 64'h0, 64'h0, 64'd12);
    check("no_cache_relaunch", start_cnt, s0 + 1);
`endif

    repeat (3) step();
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
